// File: rtl/arm_fetch_pkg.sv
// Shared types for the LEGv8 instruction fetch stage.
// Holds the fetch FSM states and the buffered {word, pc} entry.
package arm_fetch_pkg;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam int INSTR_WIDTH     = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int MAX_ADDR_WIDTH  = 64;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]    word;
    logic [MAX_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {word, pc} entries.
// Flush wins over push and pop; push at full is accepted with a pop.
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    if (p == LAST_C) return '0;
    return p + 1'b1;
  endfunction

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  // Pointer, count and storage updates
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL_C) || do_pop);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = nxt(wr_q);
      end
      if (do_pop) begin
        rd_d = nxt(rd_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Byte-serial big-endian fetch stage for the LEGv8 core.
// Assembles 32-bit words, buffers them with PC, flushes on redirect.
module instruction_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  output logic                  MEM_REQ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [7:0]            MEM_RDATA,
  input  logic                  MEM_ACK,
  output logic [31:0]           INSTRUCTION,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_PC
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C =
    ADDR_WIDTH'(BYTES_PER_INSTR);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] target_pc_q, target_pc_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;

  logic                  mem_req;
  logic                  push, pop, flush;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  fetch_entry_t          push_entry, head;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  unused_redir_lsb;

  assign redir_pc = {REDIRECT_PC[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redir_lsb = ^REDIRECT_PC[1:0];

  // A new word is only started once it owns a free FIFO slot
  assign mem_req = (state_q == DRAIN)
                || (byte_idx_q != 2'd0)
                || (fifo_count < DEPTH_C);

  assign MEM_REQ     = mem_req;
  assign MEM_ADDR    = fetch_pc_q + ADDR_WIDTH'(byte_idx_q);
  assign INSTR_VALID = !fifo_empty;
  assign INSTRUCTION = head.word;
  assign INSTR_PC    = head.pc[ADDR_WIDTH-1:0];
  assign pop         = INSTR_VALID && INSTR_READY;

  assign push_entry.word = {word_buf_q, MEM_RDATA};
  assign push_entry.pc   = MAX_ADDR_WIDTH'(fetch_pc_q);

  // Fetch FSM: byte assembly, redirect and drain of abandoned request
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    target_pc_d = target_pc_q;
    byte_idx_d  = byte_idx_q;
    word_buf_d  = word_buf_q;
    push        = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (REDIRECT) begin
          flush = 1'b1;
          if (mem_req && !MEM_ACK) begin
            target_pc_d = redir_pc;
            state_d     = DRAIN;
          end else begin
            fetch_pc_d = redir_pc;
            byte_idx_d = 2'd0;
          end
        end else if (mem_req && MEM_ACK) begin
          if (byte_idx_q == 2'd3) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + STEP_C;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            unique case (byte_idx_q)
              2'd0:    word_buf_d[23:16] = MEM_RDATA;
              2'd1:    word_buf_d[15:8]  = MEM_RDATA;
              default: word_buf_d[7:0]   = MEM_RDATA;
            endcase
          end
        end
      end
      DRAIN: begin
        if (REDIRECT) begin
          flush       = 1'b1;
          target_pc_d = redir_pc;
        end
        if (MEM_ACK) begin
          fetch_pc_d = REDIRECT ? redir_pc : target_pc_q;
          byte_idx_d = 2'd0;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Fetch state registers
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      target_pc_q <= RESET_PC;
      byte_idx_q  <= 2'd0;
      word_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      target_pc_q <= target_pc_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLOCK),
    .rst_n(RESET_N),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(push_entry),
    .head (head),
    .count(fifo_count),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Cycle table for streaming/backpressure plus corner sequences.
module tb_instruction_fetch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic [7:0]  MEM_RDATA;
  logic        MEM_ACK;
  logic [31:0] INSTRUCTION;
  logic [63:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        REDIRECT;
  logic [63:0] REDIRECT_PC;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        req;
    logic [63:0] addr;
    logic        vld;
    logic        chk_d;
    logic [31:0] ins;
    logic [63:0] pc;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [7:0] mbyte(input logic [63:0] a);
    case (a)
      64'd0:   return 8'hF8;
      64'd1:   return 8'h40;
      64'd2:   return 8'h01;
      64'd3:   return 8'h42;
      default: return a[7:0];
    endcase
  endfunction

  assign MEM_RDATA = mbyte(MEM_ADDR);

  always #5 CLOCK = ~CLOCK;

  instruction_fetch_unit dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .MEM_REQ    (MEM_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_RDATA  (MEM_RDATA),
    .MEM_ACK    (MEM_ACK),
    .INSTRUCTION(INSTRUCTION),
    .INSTR_PC   (INSTR_PC),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic req,
                         input logic [63:0] addr, input logic vld);
    chk({tag, ".req"}, 64'(MEM_REQ), 64'(req));
    chk({tag, ".addr"}, MEM_ADDR, addr);
    chk({tag, ".valid"}, 64'(INSTR_VALID), 64'(vld));
  endtask

  task automatic chk_word(input string tag, input logic [31:0] ins,
                          input logic [63:0] pc);
    chk({tag, ".instr"}, 64'(INSTRUCTION), 64'(ins));
    chk({tag, ".pc"}, INSTR_PC, pc);
  endtask

  task automatic drive(input logic ack, input logic rdy,
                       input logic red, input logic [63:0] rpc);
    MEM_ACK     = ack;
    INSTR_READY = rdy;
    REDIRECT    = red;
    REDIRECT_PC = rpc;
  endtask

  task automatic tick();
    @(negedge CLOCK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  function automatic vec_t mk(input logic ack, input logic rdy,
                              input logic req, input logic [63:0] addr,
                              input logic vld, input logic chk_d,
                              input logic [31:0] ins,
                              input logic [63:0] pc);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.req = req; v.addr = addr;
    v.vld = vld; v.chk_d = chk_d; v.ins = ins; v.pc = pc;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 1'b1, 32'h0, 64'h0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 64'h2, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 64'h3, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 64'h4, 1'b1, 1'b1, 32'hF8400142, 64'h0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b1, 64'h5, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 64'h6, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 64'h7, 1'b0, 1'b0, 32'h0, 64'h0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 64'h8, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 64'h9, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 64'hA, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 64'hB, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 64'hC, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 64'hC, 1'b1, 1'b1, 32'h04050607, 64'h4);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 32'h08090A0B, 64'h8);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 64'hD, 1'b1, 1'b1, 32'h08090A0B, 64'h8);

    // reset values while reset is held
    RESET_N = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    #1;
    chk_out("rst", 1'b1, 64'h0, 1'b0);
    chk_word("rst", 32'h0, 64'h0);
    tick();
    RESET_N = 1'b1;

    // streaming then backpressure, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld);
      if (tbl[i].chk_d)
        chk_word($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].pc);
      drive(tbl[i].ack, tbl[i].rdy, 1'b0, 64'h0);
      tick();
    end

    // redirect while byte 2 of PC 8 waits on a slow ack
    do_reset();
    for (int t = 0; t < 10; t++) begin
      drive(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
    end
    chk_out("drn.pre", 1'b1, 64'hA, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 64'h2B);
    tick();
    for (int t = 11; t < 14; t++) begin
      chk_out($sformatf("drn.hold%0d", t), 1'b1, 64'hA, 1'b0);
      drive(t == 13, 1'b1, 1'b0, 64'h0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("drn.tgt%0d", k), 1'b1, 64'h28 + 64'(k), 1'b0);
      drive(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
    end
    chk_out("drn.done", 1'b1, 64'h2C, 1'b1);
    chk_word("drn.done", 32'h28292A2B, 64'h28);

    // redirect coincident with pop and byte-3 ack
    do_reset();
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
    end
    chk_word("rp.w0", 32'hF8400142, 64'h0);
    for (int t = 4; t < 7; t++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
    end
    chk_out("rp.b3", 1'b1, 64'h7, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 64'h100);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("rp.tgt%0d", k), 1'b1, 64'h100 + 64'(k), 1'b0);
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
    end
    chk_word("rp.done", 32'h00010203, 64'h100);
    chk("rp.valid", 64'(INSTR_VALID), 64'h1);

    // PC wrap at the top of the address space (unaligned target)
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("wrap%0d", k), 1'b1,
              64'hFFFF_FFFF_FFFF_FFFC + 64'(k), 1'b0);
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
    end
    chk_out("wrap.done", 1'b1, 64'h0, 1'b1);
    chk_word("wrap.done", 32'hFCFDFEFF, 64'hFFFF_FFFF_FFFF_FFFC);

    // asynchronous reset in the middle of a word
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    chk("mid.addr", MEM_ADDR, 64'h2);
    RESET_N = 1'b0;
    #1;
    chk_out("mid.rst", 1'b1, 64'h0, 1'b0);
    chk_word("mid.rst", 32'h0, 64'h0);
    tick();
    RESET_N = 1'b1;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
    end
    chk_out("mid.refetch", 1'b1, 64'h4, 1'b1);
    chk_word("mid.refetch", 32'hF8400142, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
